// File: rtl/alu_pkg.sv
// Shared ALU control codes and execution-FSM state type for the multi-cycle datapath.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] c);
    return (c == ALU_SLL) || (c == ALU_SRL) || (c == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_comb_ops.sv
// Single-cycle ALU operations; shift codes and unknown codes fall through to AND.
module alu_comb_ops
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] y
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  always_comb begin
    y = a & b;
    case (ctrl)
      ALU_OR:   y = a | b;
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_XOR:  y = a ^ b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      default:  y = a & b;
    endcase
  end

endmodule

// File: rtl/alu_seq_exec.sv
// ALU execution unit: one-cycle logic/arith ops, iterative 1-bit-per-cycle shifts,
// valid/ready on both request and result sides with no overlap between requests.
module alu_seq_exec
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      ctrl,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  state_e               state;
  logic [3:0]           op;
  logic [XLEN-1:0]      acc;
  logic [XLEN-1:0]      acc_next;
  logic [XLEN-1:0]      comb_y;
  logic [SHAMT_W-1:0]   cnt;
  logic [SHAMT_W-1:0]   shamt;
  logic                 accept;

  function automatic logic [XLEN-1:0] shift1(input logic [3:0] c, input logic [XLEN-1:0] v);
    logic signed [XLEN-1:0] vs;
    vs = v;
    case (c)
      ALU_SLL: return v << 1;
      ALU_SRL: return v >> 1;
      default: return XLEN'(vs >>> 1);
    endcase
  endfunction

  alu_comb_ops #(.XLEN(XLEN)) u_comb (
    .ctrl (ctrl),
    .a    (a),
    .b    (b),
    .y    (comb_y)
  );

  assign shamt     = b[SHAMT_W-1:0];
  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign acc_next  = shift1(op, acc);

  // Control and result registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!is_shift(ctrl)) begin
              result <= comb_y;
              zero   <= (comb_y == '0);
              state  <= ST_DONE;
            end else if (shamt == '0) begin
              result <= a;
              zero   <= (a == '0);
              state  <= ST_DONE;
            end else begin
              state  <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (cnt == SHAMT_W'(1)) begin
            result <= acc_next;
            zero   <= (acc_next == '0);
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Shift datapath: loaded at accept, stepped once per SHIFT cycle
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) begin
      op  <= ctrl;
      acc <= a;
      cnt <= shamt;
    end else if (state == ST_SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized and directed bench for alu_seq_exec against a behavioural ALU model.
module tb_alu_seq_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  ctrl;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_exec #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  function automatic logic [31:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (c)
      4'b0001: return x | y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b0100: return x ^ y;
      4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: return (x < y) ? 32'd1 : 32'd0;
      4'b1001: return x << sh;
      4'b1010: return x >> sh;
      4'b1011: return 32'($signed(x) >>> sh);
      default: return x & y;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] c, input logic [31:0] y);
    if ((c == 4'b1001 || c == 4'b1010 || c == 4'b1011) && (y % 32) != 0)
      return int'(y % 32) + 1;
    return 1;
  endfunction

  // Issues one request (caller is just after a rising edge), scrambles the
  // inputs after accept, and waits a bounded time for out_valid.
  task automatic do_op(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] r, output logic z, output int lat, output logic rdy);
    rdy      = in_ready;
    in_valid = 1'b1;
    ctrl     = c;
    a        = x;
    b        = y;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ctrl     = 4'($urandom);
    a        = $urandom;
    b        = $urandom;
    lat      = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result;
    z = zero;
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ctrl = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b result=%h zero=%b, need 1 0 0 0",
               in_ready, out_valid, result, zero);
    end
  endtask

  task automatic run_check(input string name, input logic [3:0] c, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] r; logic z; int lat; logic rdy;
    logic [31:0] er; int el;
    er = model(c, x, y);
    el = model_lat(c, y);
    do_op(c, x, y, r, z, lat, rdy);
    tests++;
    if (rdy !== 1'b1 || r !== er || z !== (er == 32'd0) || lat != el) begin
      fails++;
      $display("FAIL %s: ctrl=%b a=%h b=%h got result=%h zero=%b lat=%0d ready=%b, need result=%h zero=%b lat=%0d ready=1",
               name, c, x, y, r, z, lat, rdy, er, (er == 32'd0), el);
    end
  endtask

  task automatic test_arith();
    run_check("add_7_5",   4'b0010, 32'd7, 32'd5);
    run_check("sub_zero",  4'b0110, 32'd5, 32'd5);
    run_check("slt_neg",   4'b0111, 32'hFFFF_FFFF, 32'd1);
    run_check("sltu_big",  4'b1000, 32'hFFFF_FFFF, 32'd1);
    run_check("or",        4'b0001, 32'hF0F0_0000, 32'h0000_0F0F);
    run_check("xor",       4'b0100, 32'hAAAA_5555, 32'hFFFF_0000);
    run_check("add_wrap",  4'b0010, 32'hFFFF_FFFF, 32'd2);
    run_check("undef_and", 4'b0011, 32'h0000_00F0, 32'h0000_003C);
  endtask

  task automatic test_shift();
    run_check("sra_4",    4'b1011, 32'h8000_0000, 32'd4);
    run_check("srl_4",    4'b1010, 32'h8000_0000, 32'd4);
    run_check("sll_31",   4'b1001, 32'd1, 32'd31);
    run_check("sll_0",    4'b1001, 32'h1234_5678, 32'd0);
    run_check("sll_0x20", 4'b1001, 32'h1234_5678, 32'h20);
    run_check("srl_out",  4'b1010, 32'd1, 32'd1);
  endtask

  task automatic test_backpressure();
    logic [31:0] r; logic z; int lat; logic rdy;
    out_ready = 1'b0;
    do_op(4'b0010, 32'd100, 32'd23, r, z, lat, rdy);
    tests++;
    if (out_valid !== 1'b1 || r !== 32'd123) begin
      fails++;
      $display("FAIL bp_first: out_valid=%b result=%h, need 1 and %h", out_valid, r, 32'd123);
    end
    in_valid = 1'b1; ctrl = 4'b0110; a = 32'd50; b = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd123 || zero !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b result=%h zero=%b, need 1 0 %h 0",
                 i, out_valid, in_ready, result, zero, 32'd123);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, need 0 1", out_valid, in_ready);
    end
    run_check("bp_next_sub", 4'b0110, 32'd50, 32'd8);
  endtask

  task automatic test_reset_midshift();
    in_valid = 1'b1; ctrl = 4'b1010; a = 32'hFFFF_0000; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b0) begin
      fails++;
      $display("FAIL midshift_reset: in_ready=%b out_valid=%b result=%h zero=%b, need 1 0 0 0",
               in_ready, out_valid, result, zero);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL midshift_stale%0d: out_valid=%b, need 0", i, out_valid);
      end
    end
    run_check("post_reset_add", 4'b0010, 32'd1, 32'd1);
  endtask

  task automatic test_random();
    logic [3:0] c; logic [31:0] x, y;
    for (int i = 0; i < 60; i++) begin
      c = 4'($urandom);
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (i % 7 == 0) y = x;
      run_check("random", c, x, y);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_backpressure();
    test_reset_midshift();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
